// File: rtl/sound_fx_if.sv
// Game-to-audio link: ball position and out-of-bounds flags toward the
// effects stage, plus the mute control and the tone status coming back.
interface sound_fx_if;
  logic       mute;
  logic [7:0] ball_x;
  logic [7:0] ball_y;
  logic       out_left;
  logic       out_right;
  logic       speaker;
  logic       busy;
  logic [1:0] tone_id;

  // Game/system side: drives position, flags and mute; observes tone state
  modport master (
    output mute, ball_x, ball_y, out_left, out_right,
    input  speaker, busy, tone_id
  );

  // Effects stage side
  modport slave (
    input  mute, ball_x, ball_y, out_left, out_right,
    output speaker, busy, tone_id
  );
endinterface

// File: rtl/sound_fx.sv
// Audio effects stage: infers wall bounces, paddle hits and goals from the
// ball trajectory and plays square-wave blips or a two-tone goal jingle.
module sound_fx #(
  parameter int DIVWIDTH     = 16,
  parameter int DURWIDTH     = 23,
  parameter int WALL_HALF    = 32000,
  parameter int PADDLE_HALF  = 16000,
  parameter int GOAL_HI_HALF = 12000,
  parameter int GOAL_LO_HALF = 24000,
  parameter int BLIP_LEN     = 1600000,
  parameter int GOAL_LEN     = 4000000
) (
  input  logic       clk,
  input  logic       reset,
  sound_fx_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, BLIP, GOAL_HI, GOAL_LO} state_t;

  // Divider and duration terminal counts (counters run 0..N-1)
  localparam logic [DIVWIDTH-1:0] WALL_HM1    = DIVWIDTH'(WALL_HALF - 1);
  localparam logic [DIVWIDTH-1:0] PADDLE_HM1  = DIVWIDTH'(PADDLE_HALF - 1);
  localparam logic [DIVWIDTH-1:0] GOAL_HI_HM1 = DIVWIDTH'(GOAL_HI_HALF - 1);
  localparam logic [DIVWIDTH-1:0] GOAL_LO_HM1 = DIVWIDTH'(GOAL_LO_HALF - 1);
  localparam logic [DURWIDTH-1:0] BLIP_END    = DURWIDTH'(BLIP_LEN - 1);
  localparam logic [DURWIDTH-1:0] GOAL_END    = DURWIDTH'(GOAL_LEN - 1);

  // ---- stage p0: registered samples of the game outputs ----
  logic [7:0] x_p0, y_p0;
  logic       outl_p0, outr_p0;

  // Sample game inputs every cycle; event logic only looks at these copies
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_p0    <= '0;
      y_p0    <= '0;
      outl_p0 <= 1'b0;
      outr_p0 <= 1'b0;
    end else begin
      x_p0    <= bus.ball_x;
      y_p0    <= bus.ball_y;
      outl_p0 <= bus.out_left;
      outr_p0 <= bus.out_right;
    end
  end

  // ---- event detection: sample versus previous sample ----
  logic [7:0] prev_x, prev_y;
  logic       dir_x, dir_y;      // last direction of travel, 1 = increasing
  logic       vld_x, vld_y;      // direction known since last serve/reset
  logic       out_prev;

  logic       out_now;
  logic       chg_x, chg_y, up_x, up_y;
  logic       rev_x, rev_y, goal_ev;
  logic [1:0] ev_pri;

  assign out_now = outl_p0 | outr_p0;
  assign chg_x   = (x_p0 != prev_x);
  assign chg_y   = (y_p0 != prev_y);
  assign up_x    = (x_p0 > prev_x);
  assign up_y    = (y_p0 > prev_y);
  // A reversal needs a known previous direction; nothing counts while out
  assign rev_x   = chg_x & vld_x & (up_x != dir_x) & ~out_now;
  assign rev_y   = chg_y & vld_y & (up_y != dir_y) & ~out_now;
  assign goal_ev = out_now & ~out_prev;

  // Track per-axis direction; holding out clears validity so the serve
  // re-seeds direction instead of looking like a bounce
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_x   <= '0;
      prev_y   <= '0;
      dir_x    <= 1'b0;
      dir_y    <= 1'b0;
      vld_x    <= 1'b0;
      vld_y    <= 1'b0;
      out_prev <= 1'b0;
    end else begin
      out_prev <= out_now;
      if (chg_x) begin
        prev_x <= x_p0;
        dir_x  <= up_x;
      end
      if (chg_y) begin
        prev_y <= y_p0;
        dir_y  <= up_y;
      end
      if (out_now)    vld_x <= 1'b0;
      else if (chg_x) vld_x <= 1'b1;
      if (out_now)    vld_y <= 1'b0;
      else if (chg_y) vld_y <= 1'b1;
    end
  end

  // Event priority: goal > paddle (x reversal) > wall (y reversal)
  always_comb begin
    ev_pri = 2'd0;
    if (goal_ev)    ev_pri = 2'd3;
    else if (rev_x) ev_pri = 2'd2;
    else if (rev_y) ev_pri = 2'd1;
  end

  // ---- stage p1: tone state machine and generators ----
  state_t              state;
  logic [1:0]          tone_id;
  logic                busy;
  logic                tone_bit;
  logic [DIVWIDTH-1:0] half_m1;
  logic [DIVWIDTH-1:0] div;
  logic [DURWIDTH-1:0] dur;
  logic [DURWIDTH-1:0] dur_end;
  logic                start;

  // Equal-or-higher priority restarts; IDLE has tone_id 0 so anything starts
  assign start   = (ev_pri != 2'd0) && (ev_pri >= tone_id);
  assign dur_end = (state == BLIP) ? BLIP_END : GOAL_END;

  // Tone sequencing, divider and duration counting with registered status
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      tone_id  <= 2'd0;
      busy     <= 1'b0;
      tone_bit <= 1'b0;
      half_m1  <= '0;
      div      <= '0;
      dur      <= '0;
    end else if (start) begin
      div      <= '0;
      dur      <= '0;
      tone_bit <= 1'b0;
      busy     <= 1'b1;
      tone_id  <= ev_pri;
      if (ev_pri == 2'd3) begin
        state   <= GOAL_HI;
        half_m1 <= GOAL_HI_HM1;
      end else begin
        state   <= BLIP;
        half_m1 <= (ev_pri == 2'd2) ? PADDLE_HM1 : WALL_HM1;
      end
    end else if (state != IDLE) begin
      if (div == half_m1) begin
        div      <= '0;
        tone_bit <= ~tone_bit;
      end else begin
        div <= div + DIVWIDTH'(1);
      end
      if (dur == dur_end) begin
        dur      <= '0;
        div      <= '0;
        tone_bit <= 1'b0;
        if (state == GOAL_HI) begin
          state   <= GOAL_LO;
          half_m1 <= GOAL_LO_HM1;
        end else begin
          state   <= IDLE;
          busy    <= 1'b0;
          tone_id <= 2'd0;
        end
      end else begin
        dur <= dur + DURWIDTH'(1);
      end
    end
  end

  // Mute only gates the pin; sequencing keeps running underneath
  assign bus.speaker = tone_bit & ~bus.mute & busy;
  assign bus.busy    = busy;
  assign bus.tone_id = tone_id;

endmodule

// File: tb/tb_sound_fx.sv
// Directed bench for sound_fx with small tone parameters. Each step predicts
// the per-cycle {busy, tone_id, speaker} into a scoreboard queue, which is
// drained one entry per clock and compared against the outputs.
module tb_sound_fx;

  localparam int WH = 4, PH = 2, GHH = 3, GLH = 5, BL = 20, GL = 30;

  logic clk;
  logic reset;
  sound_fx_if bus ();

  sound_fx #(
    .DIVWIDTH(16), .DURWIDTH(23),
    .WALL_HALF(WH), .PADDLE_HALF(PH),
    .GOAL_HI_HALF(GHH), .GOAL_LO_HALF(GLH),
    .BLIP_LEN(BL), .GOAL_LEN(GL)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] sb[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  string phase    = "init";

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_idle(input int n);
    for (int i = 0; i < n; i++) sb.push_back(4'b0000);
  endtask

  // Tone cycles k0..k0+n-1 after entry: pin rises after half cycles, period 2*half
  task automatic expect_tone(input logic [1:0] id, input int half, input int k0,
                             input int n, input bit muted);
    for (int k = k0; k < k0 + n; k++) begin
      logic spk;
      spk = muted ? 1'b0 : (((k / half) % 2) == 1);
      sb.push_back({1'b1, id, spk});
    end
  endtask

  task automatic check_one();
    logic [3:0] exp;
    logic [3:0] obs;
    exp = (sb.size() > 0) ? sb.pop_front() : 4'bxxxx;
    obs = {bus.busy, bus.tone_id, bus.speaker};
    check($sformatf("%s@%0d", phase, cyc), 32'(obs), 32'(exp));
    cyc++;
  endtask

  task automatic step(input logic [7:0] x, input logic [7:0] y,
                      input logic ol, input logic orr, input logic m);
    @(posedge clk);
    #1;
    bus.ball_x    = x;
    bus.ball_y    = y;
    bus.out_left  = ol;
    bus.out_right = orr;
    bus.mute      = m;
    @(negedge clk);
    check_one();
  endtask

  task automatic hold(input int n);
    repeat (n) step(bus.ball_x, bus.ball_y, bus.out_left, bus.out_right, bus.mute);
  endtask

  initial begin
    reset         = 1'b0;
    bus.mute      = 1'b0;
    bus.ball_x    = 8'd0;
    bus.ball_y    = 8'd0;
    bus.out_left  = 1'b0;
    bus.out_right = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_id",   32'(bus.tone_id), 32'd0);
    check("rst_spk",  32'(bus.speaker), 32'd0);
    reset = 1'b1;

    // First motion after reset only seeds direction
    phase = "seed"; cyc = 0;
    expect_idle(4);
    step(8'd5, 8'd0, 1'b0, 1'b0, 1'b0);
    step(8'd6, 8'd0, 1'b0, 1'b0, 1'b0);
    hold(2);

    // Wall blip on y reversal
    phase = "wall"; cyc = 0;
    expect_idle(5);
    expect_tone(2'd1, WH, 0, BL, 1'b0);
    expect_idle(3);
    step(8'd6, 8'd10, 1'b0, 1'b0, 1'b0);
    step(8'd6, 8'd11, 1'b0, 1'b0, 1'b0);
    step(8'd6, 8'd12, 1'b0, 1'b0, 1'b0);
    step(8'd6, 8'd11, 1'b0, 1'b0, 1'b0);
    hold(24);

    // Paddle blip on x reversal
    phase = "paddle"; cyc = 0;
    expect_idle(5);
    expect_tone(2'd2, PH, 0, BL, 1'b0);
    expect_idle(3);
    step(8'd100, 8'd11, 1'b0, 1'b0, 1'b0);
    step(8'd101, 8'd11, 1'b0, 1'b0, 1'b0);
    step(8'd102, 8'd11, 1'b0, 1'b0, 1'b0);
    step(8'd101, 8'd11, 1'b0, 1'b0, 1'b0);
    hold(24);

    // x and y reverse together: paddle only
    phase = "both"; cyc = 0;
    expect_idle(2);
    expect_tone(2'd2, PH, 0, BL, 1'b0);
    expect_idle(3);
    step(8'd102, 8'd12, 1'b0, 1'b0, 1'b0);
    hold(24);

    // Wall during paddle dropped; second paddle restarts the count
    phase = "preempt"; cyc = 0;
    expect_idle(2);
    expect_tone(2'd2, PH, 0, 10, 1'b0);
    expect_tone(2'd2, PH, 0, BL, 1'b0);
    expect_idle(3);
    step(8'd101, 8'd12, 1'b0, 1'b0, 1'b0);
    hold(4);
    step(8'd101, 8'd11, 1'b0, 1'b0, 1'b0);
    hold(4);
    step(8'd102, 8'd11, 1'b0, 1'b0, 1'b0);
    hold(24);

    // Goal preempts a wall blip; reversals while out are ignored; the first
    // move after out falls would be a reversal if direction had survived
    phase = "goal"; cyc = 0;
    expect_idle(2);
    expect_tone(2'd1, WH, 0, 5, 1'b0);
    expect_tone(2'd3, GHH, 0, GL, 1'b0);
    expect_tone(2'd3, GLH, 0, GL, 1'b0);
    expect_idle(3);
    step(8'd102, 8'd12, 1'b0, 1'b0, 1'b0);
    hold(4);
    step(8'd102, 8'd12, 1'b1, 1'b0, 1'b0);
    hold(4);
    step(8'd101, 8'd12, 1'b1, 1'b0, 1'b0);
    hold(1);
    step(8'd101, 8'd11, 1'b1, 1'b0, 1'b0);
    hold(27);
    step(8'd101, 8'd11, 1'b0, 1'b0, 1'b0);
    hold(4);
    step(8'd100, 8'd11, 1'b0, 1'b0, 1'b0);
    hold(24);

    // Right-side goal with mute mid-tone, then reset mid-tone
    phase = "mute"; cyc = 0;
    expect_idle(2);
    expect_tone(2'd3, GHH, 0, 18, 1'b0);
    expect_tone(2'd3, GHH, 18, 12, 1'b1);
    expect_tone(2'd3, GLH, 0, 10, 1'b1);
    expect_tone(2'd3, GLH, 10, 8, 1'b0);
    step(8'd100, 8'd11, 1'b0, 1'b1, 1'b0);
    hold(19);
    step(8'd100, 8'd11, 1'b0, 1'b1, 1'b1);
    hold(21);
    step(8'd100, 8'd11, 1'b0, 1'b1, 1'b0);
    hold(2);
    step(8'd100, 8'd11, 1'b0, 1'b0, 1'b0);
    hold(4);

    phase = "reset"; cyc = 0;
    expect_idle(5);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("rst_mid_busy", 32'(bus.busy), 32'd0);
    check("rst_mid_id",   32'(bus.tone_id), 32'd0);
    check("rst_mid_spk",  32'(bus.speaker), 32'd0);
    @(negedge clk);
    check_one();
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check_one();
    hold(3);

    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sound_fx.md
Name: sound_fx

Overview:
Audio effects stage downstream of the game logic. Consumes ball position and out-of-bounds flags, and infers wall bounces, paddle hits and goals. Drives a piezo/speaker pin with a square-wave tone: a short blip for bounces and hits, and a two-tone falling jingle for goals. Runs on the system clock alongside the vga and screen consumers of the game outputs.

Parameters:
DIVWIDTH, 16, width of the tone half-period counter
DURWIDTH, 23, width of the tone duration counter
WALL_HALF, 32000, half-period in clk cycles of the wall-bounce tone (500 Hz at 32 MHz)
PADDLE_HALF, 16000, half-period of the paddle-hit tone (1 kHz)
GOAL_HI_HALF, 12000, half-period of the first goal tone
GOAL_LO_HALF, 24000, half-period of the second goal tone
BLIP_LEN, 1600000, duration in cycles of a wall or paddle blip
GOAL_LEN, 4000000, duration in cycles of each goal tone

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
mute  in  1  1 = speaker forced low; state machine keeps running
ball_x  in  8  ball x position from game
ball_y  in  8  ball y position from game
out_left  in  1  ball out on left side (level)
out_right  in  1  ball out on right side (level)
speaker  out  1  square-wave tone output
busy  out  1  1 while any tone is playing
tone_id  out  2  0 idle, 1 wall, 2 paddle, 3 goal (either goal tone)

Behaviour:
- Reset (reset=0, async): state IDLE; speaker=0, busy=0, tone_id=0; prev_x/prev_y=0; direction-valid flags cleared; out_prev=0; counters 0.
- Inputs ball_x, ball_y, out_left, out_right are sampled into registers each clk. Event detection compares the current sample against the previous sample.
- Direction tracking, per axis: when the sample differs from prev, new_dir = (sample > prev), compared unsigned.
  - If the axis valid flag is 0: store new_dir and set valid. No event.
  - If the flag is 1 and new_dir != stored dir: reversal. Store new_dir.
  - prev updates on every change.
- x reversal raises a paddle event; y reversal raises a wall event. Both in the same cycle: paddle only.
- Goal event: rising edge of (out_left | out_right). While out is high, both valid flags are held clear and paddle/wall events are suppressed.
- Priority: goal(3) > paddle(2) > wall(1).
  - An event with priority >= the current tone_id preempts: restarts the tone and clears the duration and divider counters.
  - A lower-priority event is dropped.
  - An event in IDLE always starts a tone.
- States:
  - IDLE -> BLIP on a wall or paddle event. tone_id=1/2; half = WALL_HALF/PADDLE_HALF.
  - IDLE/BLIP/GOAL_LO -> GOAL_HI on a goal event.
  - GOAL_HI -> GOAL_LO after GOAL_LEN cycles.
  - GOAL_LO -> IDLE after GOAL_LEN cycles.
  - BLIP -> IDLE after BLIP_LEN cycles.
- Latency: an input change at the clk edge of cycle N is sampled at N+1 and detected combinationally. busy, tone_id and state update at the edge of N+2.
- Tone generation in any non-IDLE state:
  - The divider counts 0..half-1. At half-1 it wraps to 0 and the internal tone bit toggles.
  - The internal bit starts at 0 on every tone (re)start, so the first rising edge comes half cycles after entry.
  - Passing GOAL_HI -> GOAL_LO resets the divider and the tone bit to 0.
- The duration counter counts 0..LEN-1. The transition fires on the cycle it equals LEN-1, giving exactly LEN cycles in the state.
- speaker = tone bit & !mute & busy. In IDLE, speaker=0 and the tone bit is held 0.
- busy = (state != IDLE). tone_id = 3 in both goal states.
- Boundaries:
  - Position change by any magnitude counts as one step.
  - An unchanged position never produces an event.
  - ball_x jumping to a new serve position while out is high only re-seeds prev.
  - A reset assertion mid-tone returns all outputs to 0 immediately (async).
  - mute toggling mid-tone does not affect timing.

Test Plan:
Small params used: WALL_HALF=4, PADDLE_HALF=2, GOAL_HI_HALF=3, GOAL_LO_HALF=5, BLIP_LEN=20, GOAL_LEN=30.
1. Wall blip: y steps 10,11,12,11 with x constant -> tone_id=1, busy=1 for exactly 20 cycles. speaker toggles every 4 cycles (first rise 4 cycles after busy), then 0.
2. Paddle hit: x steps 100,101,102,101 -> tone_id=2, speaker period 4 cycles, 20 cycles busy. Then x and y reversing in the same cycle -> tone_id=2 only.
3. Preemption: paddle blip playing, then a wall reversal -> ignored (tone_id stays 2, duration not restarted). A second paddle reversal restarts the 20-cycle count.
4. Goal: out_left 0->1 during a blip -> tone_id=3, 30 cycles at half 3, then 30 cycles at half 5, then IDLE. While out_left is high, x/y reversals produce no events. The first change after out_left falls only seeds direction.
5. First motion after reset: x 0->5->6 -> no event (direction seeding only). busy stays 0.
6. mute=1 mid-goal -> speaker=0 while busy and tone_id stay unchanged, and state timing is identical to the unmuted run. reset=0 mid-tone -> speaker, busy and tone_id are 0 within the same cycle.
